// File: rtl/flp_dec_bcd24_pkg.sv
// Shared types and sizing constants for the float-to-decimal binary-to-BCD stage.
package flp_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } dec_state_t;

  localparam int DEC_WIDTH  = 24;
  localparam int DEC_DIGITS = 8;
  localparam int CNT_W      = $clog2(DEC_WIDTH + 1);

endpackage

// File: rtl/flp_dec_bcd24_add3.sv
// Single-digit double-dabble corrector: adds 3 to any digit of 5 or more before the shift.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/flp_dec_bcd24.sv
// Sequential signed binary-to-BCD converter (shift-add-3, one bit per cycle) with
// valid/ready handshakes on input and output.
module flp_dec_bcd24
  import flp_dec_pkg::*;
#(
  parameter int WIDTH  = DEC_WIDTH,
  parameter int DIGITS = DEC_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  dec_state_t state, state_nxt;

  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] mag_in;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic             sign;

  // The most negative input negates to itself, which is still the right unsigned magnitude.
  assign mag_in = data_in[WIDTH-1] ? (~data_in + WIDTH'(1)) : data_in;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_add3_digit u_adj (
      .din  (bcd[4*d +: 4]),
      .dout (bcd_adj[4*d +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = CONV;
      CONV:    if (bitcnt == CW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      bitcnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign   <= data_in[WIDTH-1];
            mag    <= mag_in;
            bcd    <= '0;
            bitcnt <= CW'(WIDTH);
          end
        end
        CONV: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          bitcnt     <= bitcnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sign  = sign;
  assign out_bcd   = bcd;

endmodule

// File: tb/tb_flp_dec_bcd24.sv
// Directed bench for flp_dec_bcd24: reset, value table, backpressure, back-to-back, mid-conversion reset.
module tb_flp_dec_bcd24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [31:0] out_bcd;

  int checks = 0;
  int failures = 0;

  flp_dec_bcd24 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_bcd   (out_bcd)
  );

  always #5 clk = ~clk;

  task automatic start_and_wait(input logic [23:0] val, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1;
    data_in  = val;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs in_ready=%0b out_valid=%0b required in_ready=1 out_valid=0", in_ready, out_valid);
    end
    checks++;
    if (out_sign !== 1'b0 || out_bcd !== 32'h0) begin
      failures++;
      $display("FAIL reset_data sign=%0b bcd=%h required sign=0 bcd=00000000", out_sign, out_bcd);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_values;
    logic [23:0] vin  [5] = '{24'h000000, 24'h7FFFFF, 24'h01E240, 24'hFFFFFF, 24'h800000};
    logic        vsgn [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] vbcd [5] = '{32'h00000000, 32'h08388607, 32'h00123456, 32'h00000001, 32'h08388608};
    int lat;
    bit bad;
    for (int i = 0; i < 5; i++) begin
      start_and_wait(vin[i], lat);
      checks++;
      if (lat !== 24) begin
        failures++;
        $display("FAIL latency[%0d] got=%0d required=24", i, lat);
      end
      checks++;
      if (out_sign !== vsgn[i]) begin
        failures++;
        $display("FAIL sign[%0d] got=%0b required=%0b", i, out_sign, vsgn[i]);
      end
      checks++;
      if (out_bcd !== vbcd[i]) begin
        failures++;
        $display("FAIL bcd[%0d] got=%h required=%h", i, out_bcd, vbcd[i]);
      end
      bad = 1'b0;
      for (int d = 0; d < 8; d++) if (out_bcd[4*d +: 4] > 4'd9) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL nibble_range[%0d] got=%h required all digits <= 9", i, out_bcd);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_accept[%0d] in_ready=%0b out_valid=%0b required 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_and_wait(24'hFED4A0, lat);
    in_valid = 1'b1;
    data_in  = 24'h000123;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sign !== 1'b1 || out_bcd !== 32'h00076640 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure[%0d] valid=%0b sign=%0b bcd=%h in_ready=%0b required 1/1/00076640/0",
                 c, out_valid, out_sign, out_bcd, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] vin  [3] = '{24'h000001, 24'hFFFF9C, 24'h0F4240};
    logic        vsgn [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] vbcd [3] = '{32'h00000001, 32'h00000100, 32'h01000000};
    int acc_cyc [3];
    int nacc, nres;
    bit acc;
    nacc = 0;
    nres = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    data_in   = vin[0];
    for (int cyc = 0; cyc < 90; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (nres >= 3) begin
          failures++;
          $display("FAIL b2b_extra_result got=%h required none", out_bcd);
        end else if (out_sign !== vsgn[nres] || out_bcd !== vbcd[nres]) begin
          failures++;
          $display("FAIL b2b_result[%0d] sign=%0b bcd=%h required sign=%0b bcd=%h",
                   nres, out_sign, out_bcd, vsgn[nres], vbcd[nres]);
        end
        nres++;
      end
      if (acc) begin
        if (nacc < 3) acc_cyc[nacc] = cyc;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (nacc < 3) data_in = vin[nacc];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nacc !== 3 || nres !== 3) begin
      failures++;
      $display("FAIL b2b_counts accepts=%0d results=%0d required 3/3", nacc, nres);
    end
    if (nacc == 3) begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (acc_cyc[k] - acc_cyc[k-1] !== 26) begin
          failures++;
          $display("FAIL b2b_interval[%0d] got=%0d required=26", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv;
    int lat, seen;
    in_valid = 1'b1;
    data_in  = 24'h000064;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset valid=%0b in_ready=%0b bcd=%h required 0/1/00000000", out_valid, in_ready, out_bcd);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL discarded_result out_valid_cycles=%0d required=0", seen);
    end
    start_and_wait(24'h000064, lat);
    checks++;
    if (lat !== 24 || out_sign !== 1'b0 || out_bcd !== 32'h00000100) begin
      failures++;
      $display("FAIL after_reset lat=%0d sign=%0b bcd=%h required 24/0/00000100", lat, out_sign, out_bcd);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
